dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets several cores share one single-port data memory.
// Each transaction is IDLE -> GRANT -> (RDWAIT) -> DONE, so it completes with a one-cycle ack.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_CORES-1:0]        read_MD,
    input  logic [NUM_CORES-1:0]        write_MD,
    input  logic [NUM_CORES*ADDR_W-1:0] ar_in,
    input  logic [NUM_CORES*DATA_W-1:0] dmem_wdata_in,
    output logic [NUM_CORES-1:0]        ack,
    output logic [DATA_W-1:0]           dmem_rdata_out,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_we,
    output logic                        mem_re,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [2:0]                  grant_id,
    output logic [1:0]                  state_dbg
);

    // Handshake: a core raises read_MD/write_MD with address and data and holds them
    // until it sees its ack bit; the ack is the single-cycle completion of that request.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        RDWAIT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          grant_id_q, grant_id_d;
    logic [2:0]          last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NUM_CORES-1:0] req;
    logic                 found_hi, found_lo;
    logic [2:0]           hi_idx, lo_idx;
    logic                 win_found;
    logic [2:0]           win_idx;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic                 sel_wr;
    logic                 grant_now;

    assign req = read_MD | write_MD;

    // Round-robin: the first requester above last_grant wins, else the lowest requester.
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        hi_idx   = 3'd0;
        lo_idx   = 3'd0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (req[k] && !found_hi && (k > int'(last_grant_q))) begin
                found_hi = 1'b1;
                hi_idx   = 3'(k);
            end
            if (req[k] && !found_lo) begin
                found_lo = 1'b1;
                lo_idx   = 3'(k);
            end
        end
        win_found = found_lo;
        win_idx   = found_hi ? hi_idx : lo_idx;
    end

    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (win_idx == 3'(k)) begin
                sel_addr  = ar_in[k*ADDR_W +: ADDR_W];
                sel_wdata = dmem_wdata_in[k*DATA_W +: DATA_W];
                sel_wr    = write_MD[k];
            end
        end
    end

    assign grant_now = (state_q == GRANT) && win_found;

    always_comb begin
        state_d      = state_q;
        grant_id_d   = grant_id_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (|req) state_d = GRANT;
            end
            GRANT: begin
                if (win_found) begin
                    grant_id_d = win_idx;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    state_d    = sel_wr ? DONE : RDWAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            RDWAIT: begin
                rdata_d = mem_rdata;
                state_d = DONE;
            end
            DONE: begin
                last_grant_d = grant_id_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            grant_id_q   <= 3'd0;
            last_grant_q <= 3'(NUM_CORES - 1);
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_id_q   <= grant_id_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // Memory-side outputs follow the winner only during GRANT and hold otherwise.
    assign mem_we         = grant_now && sel_wr;
    assign mem_re         = grant_now && !sel_wr;
    assign mem_addr       = grant_now ? sel_addr : addr_q;
    assign mem_wdata      = grant_now ? sel_wdata : wdata_q;
    assign grant_id       = grant_now ? win_idx : grant_id_q;
    assign busy           = (state_q != IDLE);
    assign dmem_rdata_out = rdata_q;
    assign state_dbg      = state_q;

    always_comb begin
        ack = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            ack[k] = (state_q == DONE) && (grant_id_q == 3'(k));
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single read/write, read+write priority,
// round-robin order, wrap, withdrawn request and reset in the middle of a read.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  read_md;
  logic [3:0]  write_md;
  logic [63:0] ar_in;
  logic [63:0] wdata_in;
  logic [3:0]  ack;
  logic [15:0] dmem_rdata_out;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic        busy;
  logic [2:0]  grant_id;
  logic [1:0]  state_dbg;

  int total = 0;
  int bad   = 0;

  dmem_arbiter #(.NUM_CORES(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .read_MD        (read_md),
    .write_MD       (write_md),
    .ar_in          (ar_in),
    .dmem_wdata_in  (wdata_in),
    .ack            (ack),
    .dmem_rdata_out (dmem_rdata_out),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_we         (mem_we),
    .mem_re         (mem_re),
    .mem_rdata      (mem_rdata),
    .busy           (busy),
    .grant_id       (grant_id),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_core(input int k, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d);
    read_md[k]         = rd;
    write_md[k]        = wr;
    ar_in[k*16 +: 16]    = a;
    wdata_in[k*16 +: 16] = d;
  endtask

  task automatic clear_reqs();
    read_md  = 4'b0000;
    write_md = 4'b0000;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_ack"},  32'(ack), 32'h0);
    chk({tag, "_we"},   32'(mem_we), 32'h0);
    chk({tag, "_re"},   32'(mem_re), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  logic [3:0]  exp_ack;
  logic [15:0] exp_rd;

  initial begin
    reset     = 1'b0;
    read_md   = '0;
    write_md  = '0;
    ar_in     = '0;
    wdata_in  = '0;
    mem_rdata = 16'h0000;
    tick();
    tick();

    // reset state
    chk_idle_outs("rst");
    chk("rst_gid",   32'(grant_id), 32'h0);
    chk("rst_addr",  32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rdout", 32'(dmem_rdata_out), 32'h0);
    chk("rst_state", 32'(state_dbg), 32'h0);
    reset = 1'b1;
    tick();

    // single write from core 1
    set_core(1, 1'b0, 1'b1, 16'h0012, 16'h1234);
    chk("wr_idle_busy", 32'(busy), 32'h0);
    tick();
    chk("wr_g_we",    32'(mem_we), 32'h1);
    chk("wr_g_re",    32'(mem_re), 32'h0);
    chk("wr_g_addr",  32'(mem_addr), 32'h0012);
    chk("wr_g_wdata", 32'(mem_wdata), 32'h1234);
    chk("wr_g_gid",   32'(grant_id), 32'h1);
    chk("wr_g_busy",  32'(busy), 32'h1);
    chk("wr_g_ack",   32'(ack), 32'h0);
    tick();
    chk("wr_d_ack",   32'(ack), 32'b0010);
    chk("wr_d_we",    32'(mem_we), 32'h0);
    chk("wr_d_addr",  32'(mem_addr), 32'h0012);
    chk("wr_d_rdout", 32'(dmem_rdata_out), 32'h0);
    clear_reqs();
    tick();
    chk_idle_outs("wr_end");
    chk("wr_end_wdata", 32'(mem_wdata), 32'h1234);

    // single read from core 2
    set_core(2, 1'b1, 1'b0, 16'h0040, 16'h0000);
    mem_rdata = 16'hDEAD;
    tick();
    chk("rd_g_re",   32'(mem_re), 32'h1);
    chk("rd_g_we",   32'(mem_we), 32'h0);
    chk("rd_g_addr", 32'(mem_addr), 32'h0040);
    chk("rd_g_gid",  32'(grant_id), 32'h2);
    tick();
    chk("rd_w_state", 32'(state_dbg), 32'h2);
    chk("rd_w_re",    32'(mem_re), 32'h0);
    chk("rd_w_ack",   32'(ack), 32'h0);
    mem_rdata = 16'hBEEF;
    tick();
    chk("rd_d_ack",   32'(ack), 32'b0100);
    chk("rd_d_rdout", 32'(dmem_rdata_out), 32'hBEEF);
    mem_rdata = 16'h5555;
    clear_reqs();
    tick();
    chk_idle_outs("rd_end");
    chk("rd_end_rdout", 32'(dmem_rdata_out), 32'hBEEF);

    // core 0 read and write together: treated as a write
    set_core(0, 1'b1, 1'b1, 16'h0100, 16'hA5A5);
    tick();
    chk("rw_g_we",    32'(mem_we), 32'h1);
    chk("rw_g_re",    32'(mem_re), 32'h0);
    chk("rw_g_gid",   32'(grant_id), 32'h0);
    chk("rw_g_addr",  32'(mem_addr), 32'h0100);
    chk("rw_g_wdata", 32'(mem_wdata), 32'hA5A5);
    tick();
    chk("rw_d_ack",   32'(ack), 32'b0001);
    chk("rw_d_re",    32'(mem_re), 32'h0);
    chk("rw_d_rdout", 32'(dmem_rdata_out), 32'hBEEF);
    clear_reqs();
    tick();

    // cores 0 and 3, last_grant=0 -> core 3 first, then wrap to core 0
    set_core(0, 1'b1, 1'b0, 16'h0010, 16'h0000);
    set_core(3, 1'b1, 1'b0, 16'h0300, 16'h0000);
    tick();
    chk("rr3_g_gid",  32'(grant_id), 32'h3);
    chk("rr3_g_addr", 32'(mem_addr), 32'h0300);
    tick();
    mem_rdata = 16'h3333;
    tick();
    chk("rr3_d_ack",   32'(ack), 32'b1000);
    chk("rr3_d_rdout", 32'(dmem_rdata_out), 32'h3333);
    read_md[3] = 1'b0;
    tick();
    chk("rr0_idle_ack", 32'(ack), 32'h0);
    tick();
    chk("rr0_g_gid",  32'(grant_id), 32'h0);
    chk("rr0_g_addr", 32'(mem_addr), 32'h0010);
    tick();
    mem_rdata = 16'h0A0A;
    tick();
    chk("rr0_d_ack",   32'(ack), 32'b0001);
    chk("rr0_d_rdout", 32'(dmem_rdata_out), 32'h0A0A);
    clear_reqs();
    tick();

    // read withdrawn after grant still completes
    set_core(2, 1'b1, 1'b0, 16'h0222, 16'h0000);
    tick();
    chk("wd_g_gid", 32'(grant_id), 32'h2);
    chk("wd_g_re",  32'(mem_re), 32'h1);
    tick();
    clear_reqs();
    mem_rdata = 16'h2C2C;
    tick();
    chk("wd_d_ack",   32'(ack), 32'b0100);
    chk("wd_d_rdout", 32'(dmem_rdata_out), 32'h2C2C);
    tick();
    chk_idle_outs("wd_end");

    // fresh reset, then all four cores read continuously
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) set_core(k, 1'b1, 1'b0, 16'(16'h1000 + k), 16'h0000);
    for (int t = 0; t < 8; t++) begin
      exp_ack = 4'b0001 << (t % 4);
      exp_rd  = 16'(16'hC000 + t);
      chk("all_i_state", 32'(state_dbg), 32'h0);
      tick();
      chk("all_g_gid",  32'(grant_id), 32'(t % 4));
      chk("all_g_re",   32'(mem_re), 32'h1);
      chk("all_g_addr", 32'(mem_addr), 32'(16'h1000 + (t % 4)));
      chk("all_g_ack",  32'(ack), 32'h0);
      tick();
      chk("all_w_ack", 32'(ack), 32'h0);
      mem_rdata = exp_rd;
      tick();
      chk("all_d_ack",   32'(ack), 32'(exp_ack));
      chk("all_d_rdout", 32'(dmem_rdata_out), 32'(exp_rd));
      tick();
    end
    clear_reqs();
    tick();

    // reset in RDWAIT abandons the read; core 3 is served after release
    set_core(3, 1'b1, 1'b0, 16'h0333, 16'h0000);
    tick();
    chk("rw3_g_gid", 32'(grant_id), 32'h3);
    tick();
    chk("rw3_w_state", 32'(state_dbg), 32'h2);
    chk("rw3_w_busy",  32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    chk_idle_outs("rst_mid");
    chk("rst_mid_gid",   32'(grant_id), 32'h0);
    chk("rst_mid_addr",  32'(mem_addr), 32'h0);
    chk("rst_mid_rdout", 32'(dmem_rdata_out), 32'h0);
    tick();
    chk("rst_hold_ack", 32'(ack), 32'h0);
    reset = 1'b1;
    tick();
    chk("rel_g_gid",  32'(grant_id), 32'h3);
    chk("rel_g_re",   32'(mem_re), 32'h1);
    chk("rel_g_addr", 32'(mem_addr), 32'h0333);
    tick();
    mem_rdata = 16'h3E3E;
    tick();
    chk("rel_d_ack",   32'(ack), 32'b1000);
    chk("rel_d_rdout", 32'(dmem_rdata_out), 32'h3E3E);
    clear_reqs();
    tick();
    chk_idle_outs("final");

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // bound on total run time
  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
